// File: rtl/irq_entry_sequencer.sv
// Interrupt entry/exit sequencer: captures the controller's interrupt, waits for an
// instruction boundary, saves mepc/mcause, redirects to the trap vector and handles mret.
module irq_entry_sequencer #(
    parameter bit VECTORED_EN = 1'b1,
    parameter int CAUSE_W     = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        int_i,
    input  logic [31:0] mcause_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        mret_i,
    output logic        stall_o,
    output logic        csr_we_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mcause_o,
    output logic [1:0]  pc_sel_o,
    output logic [31:0] pc_target_o,
    output logic        int_rst_o,
    output logic        in_handler_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BND,
        SAVE,
        VECTOR,
        HANDLER
    } state_t;

    localparam logic [1:0] PC_NORMAL = 2'b00;
    localparam logic [1:0] PC_TRAP   = 2'b01;
    localparam logic [1:0] PC_MEPC   = 2'b10;

    state_t               state;
    state_t               state_nxt;
    logic                 pending;
    logic [CAUSE_W-1:0]   pend_cause;
    logic [CAUSE_W-1:0]   cause_q;
    logic [31:0]          mepc_q;

    logic                 handler_exit;
    logic                 pend_hit;
    logic [CAUSE_W-1:0]   pend_src;
    logic [31:0]          cause_ext;
    logic [31:0]          vec_base;
    logic [31:0]          vec_target;

    // mepc_i is not needed: the return address reaches the core through the CSR file's own mux
    logic unused_mepc;
    assign unused_mepc = ^mepc_i;

    assign handler_exit = (state == HANDLER) && mret_i;
    // An interrupt arriving in the very mret cycle is treated like an already-pending one
    assign pend_hit     = pending || int_i;
    assign pend_src     = int_i ? mcause_i[CAUSE_W-1:0] : pend_cause;

    assign cause_ext  = {{(32-CAUSE_W){1'b0}}, cause_q};
    assign vec_base   = {mtvec_i[31:2], 2'b00};
    assign vec_target = (VECTORED_EN && (mtvec_i[1:0] == 2'b01))
                        ? (vec_base + (cause_ext << 2))
                        : vec_base;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (int_i) begin
                    state_nxt = stall_i ? WAIT_BND : SAVE;
                end
            end
            WAIT_BND: begin
                if (!stall_i) begin
                    state_nxt = SAVE;
                end
            end
            SAVE:    state_nxt = VECTOR;
            VECTOR:  state_nxt = HANDLER;
            HANDLER: begin
                if (mret_i) begin
                    state_nxt = pend_hit ? WAIT_BND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending    <= 1'b0;
            pend_cause <= '0;
            cause_q    <= '0;
            mepc_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_i) begin
                        cause_q <= mcause_i[CAUSE_W-1:0];
                        if (!stall_i) begin
                            mepc_q <= pc_i;
                        end
                    end
                end
                WAIT_BND: begin
                    if (!stall_i) begin
                        mepc_q <= pc_i;
                    end
                end
                HANDLER: begin
                    if (mret_i && pend_hit) begin
                        cause_q <= pend_src;
                    end
                end
                default: ;
            endcase

            // Single pending slot: a newer pulse overwrites, handler exit consumes it
            if (handler_exit) begin
                pending <= 1'b0;
            end else if (int_i && (state != IDLE)) begin
                pending    <= 1'b1;
                pend_cause <= mcause_i[CAUSE_W-1:0];
            end
        end
    end

    always_comb begin
        stall_o      = 1'b0;
        csr_we_o     = 1'b0;
        mepc_o       = mepc_q;
        mcause_o     = cause_ext;
        pc_sel_o     = PC_NORMAL;
        pc_target_o  = '0;
        int_rst_o    = 1'b0;
        in_handler_o = 1'b0;
        case (state)
            IDLE: begin
                if (mret_i) begin
                    pc_sel_o = PC_MEPC;
                end
            end
            SAVE: begin
                stall_o  = 1'b1;
                csr_we_o = 1'b1;
                mcause_o = {1'b1, cause_ext[30:0]};
            end
            VECTOR: begin
                stall_o     = 1'b1;
                pc_sel_o    = PC_TRAP;
                pc_target_o = vec_target;
            end
            HANDLER: begin
                in_handler_o = 1'b1;
                if (mret_i) begin
                    pc_sel_o  = PC_MEPC;
                    int_rst_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
